bcd_down_counter: RTL and testbench
===================================

Name: bcd_down_counter

Overview:
Loadable multi-digit BCD down counter, the count-down counterpart of the team's decade up counter. It is used as a programmable interval timer. Software or an upstream FSM loads a decimal preset, then the counter decrements once per enabled cycle. It flags terminal count and optionally reloads the preset for periodic operation. Digits cascade internally through per-digit borrow, so each digit wraps 0 -> 9.

Parameters:
DIGITS, 2, number of BCD digits; counter width is 4*DIGITS bits.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RESET  input  1  synchronous, active-high reset.
LOAD  input  1  load LOAD_VAL into count and reload register this cycle.
LOAD_VAL  input  4*DIGITS  BCD preset; digit k occupies bits [4k+3:4k].
EN  input  1  count enable; one decrement per cycle while asserted and running.
AUTO_RELOAD  input  1  1 = periodic mode (reload at terminal count); 0 = one-shot.
Q  output  4*DIGITS  current BCD count, registered.
RUNNING  output  1  high in RUN state, registered.
ZERO  output  1  combinational, (Q == 0).
DONE  output  1  registered one-cycle pulse on terminal count.

Behaviour:
- Priority each cycle: RESET > LOAD > EN.
- Reset:
  - Q = 0, reload register = 0, state = IDLE, RUNNING = 0, DONE = 0, ZERO = 1.
  - RESET in the middle of a count abandons that count immediately. No DONE is issued.
- States: IDLE (not counting) and RUN (counting). RUNNING = (state == RUN).
- Load sanitising: any LOAD_VAL digit greater than 9 is clamped to 9, per digit, independently.
- LOAD:
  - Q and the reload register both take the sanitised value on the next edge.
  - Next state is RUN if the sanitised value is non-zero, otherwise IDLE.
  - DONE = 0 on that edge.
  - LOAD while already in RUN restarts the count from the new value.
  - LOAD and EN asserted in the same cycle: the load wins and there is no decrement.
- Decrement (state RUN, EN = 1, no LOAD/RESET):
  - Digit 0 decrements by 1.
  - Any digit that is 0 while a borrow comes in becomes 9 and propagates the borrow upward.
  - A digit with a non-zero value absorbs the borrow.
- Terminal event (state RUN, EN = 1, Q == 1, i.e. digit 0 = 1 and all upper digits = 0):
  - AUTO_RELOAD = 0: Q <- 0, state <- IDLE, DONE = 1 for exactly one cycle, coincident with Q first showing 0.
  - AUTO_RELOAD = 1: Q <- reload register, state stays RUN, DONE = 1 for one cycle. Q never shows 0.
  - AUTO_RELOAD is sampled only at the terminal event.
  - Period in reload mode = preset value, in enabled cycles.
- EN = 0: Q and state hold. DONE = 0.
- IDLE: EN is ignored. Q holds (no wrap from 0 to 99..9).
- DONE is 0 in every cycle other than the one following a terminal event.
- Latency: Q reflects a LOAD or decrement one clock after the sampling edge. There is no combinational path from inputs to Q, DONE or RUNNING.
- Outside a LOAD, Q never holds a non-BCD digit.

Test Plan:
- Reset: drive RESET = 1 for 2 cycles with LOAD = 1, EN = 1 -> Q = 0x00, RUNNING = 0, DONE = 0, ZERO = 1. Release, then 5 EN cycles -> Q stays 0x00.
- One-shot: LOAD 0x25, AUTO_RELOAD = 0, EN held high -> Q = 0x25, 0x24 … 0x20, 0x19 … 0x01, 0x00. DONE is high only in the cycle Q becomes 0x00, which is the 25th enable. RUNNING then drops to 0. Further EN leaves Q = 0x00.
- Borrow and clamp: LOAD 0x10, one EN -> Q = 0x09. LOAD 0xAF -> Q = 0x99. With DIGITS = 3, LOAD 0x100 then one EN -> Q = 0x099.
- Auto-reload: LOAD 0x03, AUTO_RELOAD = 1, EN held high -> Q = 03, 02, 01, 03, 02, 01, 03. DONE pulses on each transition 01 -> 03. RUNNING stays 1.
- Zero preset and gaps: LOAD 0x00 -> RUNNING = 0, DONE = 0, and EN has no effect. LOAD 0x05, then EN toggled 1,0,0,1 -> Q = 04, 04, 04, 03.
- Collisions: LOAD 0x40 with EN = 1 in the same cycle -> Q = 0x40, not 0x39. At Q = 0x12, assert RESET with EN = 1 -> next Q = 0x00 and DONE = 0.

Source files
------------

// File: rtl/bcd_down_counter_if.sv
// Control/status bundle for the loadable BCD down counter.
// The master drives load/enable controls; the slave presents count and flags.
interface bcd_down_counter_if #(
    parameter int DIGITS = 2
);
    logic                  LOAD;
    logic [4*DIGITS-1:0]   LOAD_VAL;
    logic                  EN;
    logic                  AUTO_RELOAD;
    logic [4*DIGITS-1:0]   Q;
    logic                  RUNNING;
    logic                  ZERO;
    logic                  DONE;

    modport master (
        output LOAD,
        output LOAD_VAL,
        output EN,
        output AUTO_RELOAD,
        input  Q,
        input  RUNNING,
        input  ZERO,
        input  DONE
    );

    modport slave (
        input  LOAD,
        input  LOAD_VAL,
        input  EN,
        input  AUTO_RELOAD,
        output Q,
        output RUNNING,
        output ZERO,
        output DONE
    );
endinterface

// File: rtl/bcd_down_counter.sv
// Loadable multi-digit BCD down counter used as a programmable interval timer,
// with one-shot or periodic (auto-reload) terminal-count behaviour.
//
// state | meaning
// IDLE  | not counting; EN ignored, Q holds
// RUN   | decrement once per enabled cycle until terminal count
module bcd_down_counter #(
    parameter int DIGITS = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    bcd_down_counter_if.slave bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nxt;
    logic [W-1:0]   q_r;
    logic [W-1:0]   q_nxt;
    logic [W-1:0]   reload_r;
    logic [W-1:0]   reload_nxt;
    logic           done_r;
    logic           done_nxt;
    logic [W-1:0]   load_clean;
    logic [W-1:0]   q_dec;
    logic           at_terminal;

    // Clamp each digit above 9 to 9 independently.
    function automatic logic [W-1:0] sanitise(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                r[4*k +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_decrement(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign load_clean  = sanitise(bus.LOAD_VAL);
    assign q_dec       = bcd_decrement(q_r);
    assign at_terminal = (q_r == W'(1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r  <= IDLE;
            q_r      <= '0;
            reload_r <= '0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            q_r      <= q_nxt;
            reload_r <= reload_nxt;
            done_r   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_r;
        q_nxt      = q_r;
        reload_nxt = reload_r;
        done_nxt   = 1'b0;

        if (bus.LOAD) begin
            q_nxt      = load_clean;
            reload_nxt = load_clean;
            state_nxt  = (load_clean != '0) ? RUN : IDLE;
        end else if (state_r == RUN && bus.EN) begin
            if (at_terminal) begin
                done_nxt = 1'b1;
                // Periodic mode skips the zero state so the period equals the preset.
                if (bus.AUTO_RELOAD) begin
                    q_nxt = reload_r;
                end else begin
                    q_nxt     = '0;
                    state_nxt = IDLE;
                end
            end else begin
                q_nxt = q_dec;
            end
        end
    end

    assign bus.Q       = q_r;
    assign bus.RUNNING = (state_r == RUN);
    assign bus.DONE    = done_r;
    assign bus.ZERO    = (q_r == '0);
endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench for bcd_down_counter: directed stimulus pushes expected
// post-edge state; per-instance monitors pop and compare after each edge.
module tb_bcd_down_counter;
    logic CLK;
    logic RESET;

    int checks = 0;
    int errors = 0;

    bcd_down_counter_if #(.DIGITS(2)) bus2 ();
    bcd_down_counter_if #(.DIGITS(3)) bus3 ();

    bcd_down_counter #(.DIGITS(2)) dut2 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus2.slave)
    );

    bcd_down_counter #(.DIGITS(3)) dut3 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus3.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {q, running, done}
    logic [9:0]  exp2_q[$];
    logic [13:0] exp3_q[$];

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        logic [9:0] e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp2_q.size() > 0) begin
                e = exp2_q.pop_front();
                check_vec("q2", {4'h0, bus2.Q}, {4'h0, e[9:2]});
                check_bit("running2", bus2.RUNNING, e[1]);
                check_bit("done2", bus2.DONE, e[0]);
                check_bit("zero2", bus2.ZERO, (e[9:2] == 8'h00));
            end
        end
    end

    initial begin
        logic [13:0] e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp3_q.size() > 0) begin
                e = exp3_q.pop_front();
                check_vec("q3", bus3.Q, e[13:2]);
                check_bit("running3", bus3.RUNNING, e[1]);
                check_bit("done3", bus3.DONE, e[0]);
                check_bit("zero3", bus3.ZERO, (e[13:2] == 12'h000));
            end
        end
    end

    task automatic idle3();
        bus3.LOAD        = 1'b0;
        bus3.LOAD_VAL    = '0;
        bus3.EN          = 1'b0;
        bus3.AUTO_RELOAD = 1'b0;
    endtask

    task automatic step(input logic rst, input logic ld, input logic [7:0] val,
                        input logic en, input logic ar,
                        input logic [7:0] eq, input logic er, input logic ed);
        @(negedge CLK);
        RESET            = rst;
        bus2.LOAD        = ld;
        bus2.LOAD_VAL    = val;
        bus2.EN          = en;
        bus2.AUTO_RELOAD = ar;
        idle3();
        exp2_q.push_back({eq, er, ed});
    endtask

    task automatic step3(input logic ld, input logic [11:0] val, input logic en,
                         input logic [11:0] eq, input logic er, input logic ed);
        @(negedge CLK);
        RESET            = 1'b0;
        bus2.LOAD        = 1'b0;
        bus2.EN          = 1'b0;
        bus3.LOAD        = ld;
        bus3.LOAD_VAL    = val;
        bus3.EN          = en;
        bus3.AUTO_RELOAD = 1'b0;
        exp3_q.push_back({eq, er, ed});
    endtask

    initial begin
        logic [7:0] bcd;
        RESET            = 1'b1;
        bus2.LOAD        = 1'b0;
        bus2.LOAD_VAL    = '0;
        bus2.EN          = 1'b0;
        bus2.AUTO_RELOAD = 1'b0;
        idle3();

        // reset dominates load/enable
        step(1, 1, 8'h55, 1, 0, 8'h00, 0, 0);
        step(1, 1, 8'h55, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);

        // one-shot from 25
        step(0, 1, 8'h25, 0, 0, 8'h25, 1, 0);
        for (int n = 24; n >= 0; n--) begin
            bcd = {4'(n / 10), 4'(n % 10)};
            step(0, 0, 8'h00, 1, 0, bcd, (n != 0), (n == 0));
        end
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 1, 8'h00, 0, 0);

        // borrow and clamp
        step(0, 1, 8'h10, 0, 0, 8'h10, 1, 0);
        step(0, 0, 8'h00, 1, 0, 8'h09, 1, 0);
        step(0, 1, 8'hAF, 0, 0, 8'h99, 1, 0);
        step(0, 1, 8'h3C, 0, 0, 8'h39, 1, 0);
        step(0, 1, 8'hB2, 0, 0, 8'h92, 1, 0);

        // auto-reload period 3
        step(0, 1, 8'h03, 0, 1, 8'h03, 1, 0);
        step(0, 0, 8'h00, 1, 1, 8'h02, 1, 0);
        step(0, 0, 8'h00, 1, 1, 8'h01, 1, 0);
        step(0, 0, 8'h00, 1, 1, 8'h03, 1, 1);
        step(0, 0, 8'h00, 1, 1, 8'h02, 1, 0);
        step(0, 0, 8'h00, 1, 1, 8'h01, 1, 0);
        step(0, 0, 8'h00, 1, 1, 8'h03, 1, 1);
        // mode sampled only at terminal: switching to one-shot ends next period at 0
        step(0, 0, 8'h00, 1, 0, 8'h02, 1, 0);
        step(0, 0, 8'h00, 1, 0, 8'h01, 1, 0);
        step(0, 0, 8'h00, 1, 0, 8'h00, 0, 1);

        // zero preset
        step(0, 1, 8'h00, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);

        // enable gaps
        step(0, 1, 8'h05, 0, 0, 8'h05, 1, 0);
        step(0, 0, 8'h00, 1, 0, 8'h04, 1, 0);
        step(0, 0, 8'h00, 0, 0, 8'h04, 1, 0);
        step(0, 0, 8'h00, 0, 0, 8'h04, 1, 0);
        step(0, 0, 8'h00, 1, 0, 8'h03, 1, 0);
        // reload mid-run restarts
        step(0, 1, 8'h50, 1, 0, 8'h50, 1, 0);
        step(0, 0, 8'h00, 1, 0, 8'h49, 1, 0);

        // collisions
        step(0, 1, 8'h40, 1, 0, 8'h40, 1, 0);
        step(0, 1, 8'h13, 0, 0, 8'h13, 1, 0);
        step(0, 0, 8'h00, 1, 0, 8'h12, 1, 0);
        step(1, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        step(0, 1, 8'h01, 0, 1, 8'h01, 1, 0);
        step(1, 0, 8'h00, 1, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 1, 8'h00, 0, 0);

        // three-digit borrow chain and clamp
        step3(1, 12'h100, 0, 12'h100, 1, 0);
        step3(0, 12'h000, 1, 12'h099, 1, 0);
        step3(0, 12'h000, 1, 12'h098, 1, 0);
        step3(1, 12'hFAB, 0, 12'h999, 1, 0);
        step3(0, 12'h000, 1, 12'h998, 1, 0);
        step3(1, 12'h001, 1, 12'h001, 1, 0);
        step3(0, 12'h000, 1, 12'h000, 0, 1);

        @(negedge CLK);
        idle3();
        bus2.LOAD = 1'b0;
        bus2.EN   = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        check_vec("scoreboard_drained", 12'(exp2_q.size() + exp3_q.size()), 12'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
